ibus_rsp: RTL and testbench
===========================

IBUS_RSP -- requirements
Module: ibus_rsp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words held (power of two, 16..65536).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-004 Parameter NOP_WORD, default 32'h0000_0013, word driven when no valid data is presented.
REQ-005 Port i_clk  in  1  sole clock, all state updates on rising edge.
REQ-006 Port i_rst  in  1  reset, asynchronous, active-high.
REQ-007 Port i_ibus_req  in  1  fetch request from ibus initiator.
REQ-008 Port i_ibus_addr  in  32  fetch byte address.
REQ-009 Port o_ibus_rsp  out  1  response strobe, one cycle per accepted request.
REQ-010 Port o_ibus_data  out  32  instruction word, valid while o_ibus_rsp=1.
REQ-011 Port o_ibus_err  out  1  error flag, valid while o_ibus_rsp=1.
REQ-012 Port i_ld_we  in  1  loader write enable.
REQ-013 Port i_ld_idx  in  16  loader word index.
REQ-014 Port i_ld_data  in  32  loader write data.
REQ-015 Port o_busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, WAIT, RESP; registered state, outputs decoded from state and registers only.
REQ-017 IDLE, i_ibus_req=1 at edge: capture i_ibus_addr into addr_q, load wait counter with WAIT_CYCLES, go WAIT.
REQ-018 IDLE, i_ibus_req=0: remain IDLE, no capture.
REQ-019 WAIT, counter!=0: decrement by 1, remain WAIT.
REQ-020 WAIT, counter==0: read memory at addr_q into data_q, compute err_q, go RESP.
REQ-021 RESP: o_ibus_rsp=1 for exactly one cycle; next edge always returns to IDLE (no capture on that edge).
REQ-022 Latency: o_ibus_rsp high during the cycle after edge t0+WAIT_CYCLES+1, t0 = capture edge; WAIT_CYCLES=0 gives rsp one cycle after capture.
REQ-023 Max throughput: one response per WAIT_CYCLES+3 cycles (IDLE bubble after each RESP is mandatory).
REQ-024 o_ibus_data = data_q in RESP, NOP_WORD in all other states.
REQ-025 err_q=1 when addr_q[1:0]!=0 or (addr_q-BASE_ADDR)>>2 >= DEPTH_WORDS (unsigned, 32-bit wrap); then data_q=NOP_WORD.
REQ-026 o_ibus_err = err_q in RESP, 0 otherwise.
REQ-027 Word index = (addr_q-BASE_ADDR)>>2, low log2(DEPTH_WORDS) bits used only when in range.
REQ-028 i_ibus_req or i_ibus_addr changing after capture has no effect; the accepted transaction completes with its captured address.
REQ-029 Loader write: i_ld_we=1 at edge writes i_ld_data to mem[i_ld_idx]; i_ld_idx >= DEPTH_WORDS ignored; accepted in any state.
REQ-030 Loader write to addr_q word during WAIT before the read edge: response returns new data.
REQ-031 Loader write to addr_q word on the same edge as WAIT->RESP read: response returns old data (read-before-write).
REQ-032 o_busy = (state != IDLE).

Reset
REQ-033 i_rst=1 forces immediately, regardless of clock: state IDLE, counter 0, addr_q 0, data_q NOP_WORD, err_q 0; hence o_ibus_rsp=0, o_ibus_err=0, o_busy=0, o_ibus_data=NOP_WORD.
REQ-034 Reset in WAIT or RESP abandons the transaction; no rsp is produced for it after release.
REQ-035 Memory contents not cleared by reset; after release, first edge with i_ibus_req=1 is accepted normally.

Verification
REQ-036 WAIT_CYCLES=1, mem[0]=32'h0010_0093, req=1 addr=0 at edge 0 -> rsp=1 only in cycle after edge 2, data=32'h0010_0093, err=0, busy 1 after edges 0..2.
REQ-037 WAIT_CYCLES=0, req held high, addr 0,4,8 stepped on each rsp -> rsps spaced 3 cycles apart, data mem[0],mem[1],mem[2].
REQ-038 addr=32'h0000_0002, then addr=DEPTH_WORDS*4 -> each rsp with err=1, data=32'h0000_0013.
REQ-039 WAIT_CYCLES=3: req dropped after capture -> rsp still one pulse after 4 cycles; loader write to same word on WAIT->RESP edge -> old data returned; write one cycle earlier -> new data.
REQ-040 i_rst asserted mid-WAIT between edges -> rsp/busy low immediately, no rsp after release; memory word still reads back unchanged on next fetch.

Source files
------------

// File: rtl/ibus_rsp.sv
// rtl/ibus_rsp.sv - instruction-bus responder with loader-writable word memory
// Single-beat fetch with a fixed wait-state count; errors on misaligned or out-of-window addresses.
module ibus_rsp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ibus_req,
   input  logic [31:0] i_ibus_addr,
   output logic        o_ibus_rsp,
   output logic [31:0] o_ibus_data,
   output logic        o_ibus_err,
   input  logic        i_ld_we,
   input  logic [15:0] i_ld_idx,
   input  logic [31:0] i_ld_data,
   output logic        o_busy
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] word_idx;
   logic        addr_err;

   // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
   always_comb begin
      word_idx = (addr_q - BASE_ADDR) >> 2;
      addr_err = (addr_q[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (i_ibus_req) begin
               addr_d  = i_ibus_addr;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d   = addr_err;
               data_d  = addr_err ? NOP_WORD : mem[word_idx[AW-1:0]];
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         data_q  <= NOP_WORD;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Memory survives reset; a write on the read edge is seen only by later fetches.
   always_ff @(posedge i_clk) begin
      if (i_ld_we && ({16'd0, i_ld_idx} < 32'(DEPTH_WORDS))) begin
         mem[i_ld_idx[AW-1:0]] <= i_ld_data;
      end
   end

   always_comb begin
      o_ibus_rsp  = (state_q == ST_RESP);
      o_ibus_data = (state_q == ST_RESP) ? data_q : NOP_WORD;
      o_ibus_err  = (state_q == ST_RESP) && err_q;
      o_busy      = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_ibus_rsp.sv
// tb/tb_ibus_rsp.sv - self-checking bench for ibus_rsp
// Three instances cover zero, one and three wait states plus a small offset window.
module tb_ibus_rsp;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        req     [3];
   logic [31:0] addr    [3];
   logic        rsp     [3];
   logic [31:0] data    [3];
   logic        err     [3];
   logic        we      [3];
   logic [15:0] ld_idx  [3];
   logic [31:0] ld_data [3];
   logic        busy    [3];

   int          wc    [3];
   int          depth [3];
   logic [31:0] base  [3];
   logic [31:0] mdl   [3][1024];

   int ntests;
   int nfail;

   typedef struct {
      int          k;
      logic [31:0] a;
      logic        e;
      logic [31:0] d;
   } vec_t;

   vec_t vecs [12];

   ibus_rsp u_w1 (
      .i_clk(clk), .i_rst(rst), .i_ibus_req(req[0]), .i_ibus_addr(addr[0]),
      .o_ibus_rsp(rsp[0]), .o_ibus_data(data[0]), .o_ibus_err(err[0]),
      .i_ld_we(we[0]), .i_ld_idx(ld_idx[0]), .i_ld_data(ld_data[0]), .o_busy(busy[0])
   );

   ibus_rsp #(.WAIT_CYCLES(0)) u_w0 (
      .i_clk(clk), .i_rst(rst), .i_ibus_req(req[1]), .i_ibus_addr(addr[1]),
      .o_ibus_rsp(rsp[1]), .o_ibus_data(data[1]), .o_ibus_err(err[1]),
      .i_ld_we(we[1]), .i_ld_idx(ld_idx[1]), .i_ld_data(ld_data[1]), .o_busy(busy[1])
   );

   ibus_rsp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3)) u_w3 (
      .i_clk(clk), .i_rst(rst), .i_ibus_req(req[2]), .i_ibus_addr(addr[2]),
      .o_ibus_rsp(rsp[2]), .o_ibus_data(data[2]), .o_ibus_err(err[2]),
      .i_ld_we(we[2]), .i_ld_idx(ld_idx[2]), .i_ld_data(ld_data[2]), .o_busy(busy[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, tests=%0d", ntests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void model_rsp(input int k, input logic [31:0] a,
                                     output logic e, output logic [31:0] d);
      logic [31:0] w;
      w = (a - base[k]) >> 2;
      e = (a[1:0] != 2'b00) || (w >= 32'(depth[k]));
      d = e ? NOP : mdl[k][w[9:0]];
   endfunction

   task automatic ld_write(input int k, input int idx, input logic [31:0] d);
      @(negedge clk);
      we[k] = 1'b1; ld_idx[k] = 16'(idx); ld_data[k] = d;
      @(posedge clk); #1;
      we[k] = 1'b0;
      if (idx < depth[k]) mdl[k][idx] = d;
   endtask

   // ld_edge = n schedules a loader write to the fetched word on the n-th edge after capture.
   task automatic fetch(input int k, input logic [31:0] a, input int ld_edge,
                        input logic [31:0] ld_d, input logic exp_e,
                        input logic [31:0] exp_d, input string nm);
      int n;
      bit got;
      logic [15:0] li;
      li = 16'((a - base[k]) >> 2);
      @(negedge clk);
      req[k] = 1'b1; addr[k] = a;
      @(posedge clk); #1;
      req[k] = 1'b0; addr[k] = $urandom;
      n = 0; got = 1'b0;
      chk({nm, "_busy_cap"}, 32'(busy[k]), 32'd1);
      while (!got && n < 40) begin
         if (ld_edge == n + 1) begin
            we[k] = 1'b1; ld_idx[k] = li; ld_data[k] = ld_d;
         end
         @(posedge clk); #1;
         we[k] = 1'b0;
         n++;
         chk({nm, "_busy"}, 32'(busy[k]), 32'd1);
         if (rsp[k]) begin
            got = 1'b1;
            chk({nm, "_lat"}, 32'(n), 32'(wc[k] + 1));
            chk({nm, "_data"}, data[k], exp_d);
            chk({nm, "_err"}, 32'(err[k]), 32'(exp_e));
         end
      end
      if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      chk({nm, "_rsp_end"}, 32'(rsp[k]), 32'd0);
      chk({nm, "_busy_end"}, 32'(busy[k]), 32'd0);
      chk({nm, "_data_end"}, data[k], NOP);
      chk({nm, "_err_end"}, 32'(err[k]), 32'd0);
   endtask

   task automatic fetch_m(input int k, input logic [31:0] a, input string nm);
      logic e;
      logic [31:0] d;
      model_rsp(k, a, e, d);
      fetch(k, a, 0, 32'd0, e, d, nm);
   endtask

   initial begin
      int cyc, got, last, idx, r;
      logic [31:0] a, old_d;
      ntests = 0; nfail = 0;
      wc    = '{1, 0, 3};
      depth = '{1024, 1024, 16};
      base  = '{32'h0, 32'h0, 32'h100};
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; addr[k] = 32'd0; we[k] = 1'b0; ld_idx[k] = 16'd0; ld_data[k] = 32'd0;
         for (int i = 0; i < 1024; i++) mdl[k][i] = 32'd0;
      end
      rst = 1'b1;
      #2;
      for (int k = 0; k < 3; k++) begin
         chk("rst_rsp", 32'(rsp[k]), 32'd0);
         chk("rst_busy", 32'(busy[k]), 32'd0);
         chk("rst_err", 32'(err[k]), 32'd0);
         chk("rst_data", data[k], NOP);
      end
      #20;
      @(negedge clk);
      rst = 1'b0;

      ld_write(0, 0, 32'h0010_0093);
      ld_write(0, 1, 32'h1111_1111);
      ld_write(0, 1023, 32'hA5A5_A5A5);
      ld_write(1, 0, 32'h1111_0000);
      ld_write(1, 1, 32'h2222_0000);
      ld_write(1, 2, 32'h3333_0000);
      ld_write(2, 0, 32'hC0DE_0000);
      ld_write(2, 15, 32'hC0DE_000F);
      ld_write(2, 16, 32'hDEAD_DEAD);
      ld_write(2, 65535, 32'hBADB_AD00);

      vecs[0]  = '{0, 32'h0000_0000, 1'b0, 32'h0010_0093};
      vecs[1]  = '{0, 32'h0000_0004, 1'b0, 32'h1111_1111};
      vecs[2]  = '{0, 32'h0000_0FFC, 1'b0, 32'hA5A5_A5A5};
      vecs[3]  = '{0, 32'h0000_0002, 1'b1, NOP};
      vecs[4]  = '{0, 32'h0000_1000, 1'b1, NOP};
      vecs[5]  = '{0, 32'hFFFF_FFFC, 1'b1, NOP};
      vecs[6]  = '{1, 32'h0000_0008, 1'b0, 32'h3333_0000};
      vecs[7]  = '{2, 32'h0000_0100, 1'b0, 32'hC0DE_0000};
      vecs[8]  = '{2, 32'h0000_013C, 1'b0, 32'hC0DE_000F};
      vecs[9]  = '{2, 32'h0000_0140, 1'b1, NOP};
      vecs[10] = '{2, 32'h0000_00FC, 1'b1, NOP};
      vecs[11] = '{2, 32'h0000_0101, 1'b1, NOP};
      for (int v = 0; v < 12; v++) begin
         fetch(vecs[v].k, vecs[v].a, 0, 32'd0, vecs[v].e, vecs[v].d, $sformatf("vec%0d", v));
      end

      // Back-to-back with request held high: capture, RESP, mandatory IDLE bubble.
      @(negedge clk);
      req[1] = 1'b1; addr[1] = 32'd0;
      cyc = 0; got = 0; last = 0;
      while (got < 3 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (rsp[1]) begin
            if (got == 0) chk("b2b_first_lat", 32'(cyc), 32'd2);
            else chk("b2b_spacing", 32'(cyc - last), 32'd3);
            chk("b2b_data", data[1], mdl[1][got]);
            last = cyc;
            got++;
            addr[1] = 32'(got * 4);
         end
      end
      req[1] = 1'b0;
      chk("b2b_count", 32'(got), 32'd3);
      repeat (3) @(posedge clk);
      #1;

      ld_write(2, 5, 32'h0000_AAAA);
      old_d = mdl[2][5];
      fetch(2, 32'h114, 4, 32'h0000_BBBB, 1'b0, old_d, "ld_on_read_edge");
      mdl[2][5] = 32'h0000_BBBB;
      fetch(2, 32'h114, 3, 32'h0000_CCCC, 1'b0, 32'h0000_CCCC, "ld_before_read");
      mdl[2][5] = 32'h0000_CCCC;

      @(negedge clk);
      req[2] = 1'b1; addr[2] = 32'h114;
      @(posedge clk); #1;
      req[2] = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("midrst_rsp", 32'(rsp[2]), 32'd0);
      chk("midrst_busy", 32'(busy[2]), 32'd0);
      chk("midrst_data", data[2], NOP);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      got = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp[2] || busy[2]) got++;
      end
      chk("midrst_no_rsp", 32'(got), 32'd0);
      fetch_m(2, 32'h114, "midrst_refetch");

      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            we[k] = 1'b1; ld_idx[k] = 16'(i); ld_data[k] = $urandom;
            if (i < depth[k]) mdl[k][i] = ld_data[k];
         end
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) we[k] = 1'b0;
      end

      for (int t = 0; t < 40; t++) begin
         int k;
         k = $urandom_range(0, 2);
         idx = $urandom_range(0, depth[k] - 1);
         r = $urandom_range(0, 9);
         if (r < 6)       a = base[k] + 32'(idx * 4);
         else if (r == 6) a = base[k] + 32'(idx * 4) + 32'($urandom_range(1, 3));
         else if (r == 7) a = base[k] + 32'(depth[k] * 4) + 32'($urandom_range(0, 100) * 4);
         else if (r == 8) a = base[k] - 32'd4;
         else begin
            ld_write(k, $urandom_range(0, 2 * depth[k] - 1), $urandom);
            a = base[k] + 32'(idx * 4);
         end
         fetch_m(k, a, $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
